// File: rtl/mod_ctr_pkg.sv
// mod_ctr_pkg: shared direction encoding and legal modulus/width limits for mod_updn_ctr
package mod_ctr_pkg;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam int   MIN_MOD   = 2;
    localparam int   MIN_WIDTH = 2;
    localparam int   MAX_WIDTH = 16;
    function automatic int max_mod(input int width);
        return 1 << width;
    endfunction
endpackage

// File: rtl/mod_updn_ctr.sv
// mod_updn_ctr: runtime-programmable modulo up/down counter with load, cascade carry and modulus error pulse
module mod_updn_ctr
    import mod_ctr_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_MOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cfg_we,
    input  logic [WIDTH:0]   mod_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             cfg_err
);
    localparam logic [WIDTH:0] MIN_M = (WIDTH+1)'(MIN_MOD);
    localparam logic [WIDTH:0] MAX_M = (WIDTH+1)'(max_mod(WIDTH));
    localparam logic [WIDTH:0] RST_M = (WIDTH+1)'(DEFAULT_MOD);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "mod_updn_ctr: WIDTH out of range");
    end
    if (DEFAULT_MOD < MIN_MOD || DEFAULT_MOD > max_mod(WIDTH)) begin : g_bad_mod
        $fatal(1, "mod_updn_ctr: DEFAULT_MOD out of range");
    end

    logic [WIDTH:0]   r_mod;
    logic [WIDTH-1:0] r_out;
    logic             r_cfg_err;
    logic             r_fix;
    logic [WIDTH:0]   w_last;
    logic             w_at_last;
    logic             w_at_zero;
    logic             w_cfg_ok;
    logic [WIDTH-1:0] w_next;

    // r_fix marks the first cycle under a newly accepted modulus, when out may lie outside it
    always_comb begin
        w_last    = r_mod - 1'b1;
        w_at_last = {1'b0, r_out} == w_last;
        w_at_zero = r_out == '0;
        w_cfg_ok  = mod_val >= MIN_M && mod_val <= MAX_M;
        w_next    = load                              ? (({1'b0, load_val} < r_mod) ? load_val : '0)
                  : (r_fix && {1'b0, r_out} >= r_mod) ? '0
                  : !en                               ? r_out
                  : (up_dn == DIR_UP)                 ? (w_at_last ? '0 : r_out + 1'b1)
                  :                                     (w_at_zero ? w_last[WIDTH-1:0] : r_out - 1'b1);
    end

    assign tc      = en & ((up_dn == DIR_DN) ? w_at_zero : w_at_last);
    assign out     = r_out;
    assign cfg_err = r_cfg_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            r_mod     <= RST_M;
            r_cfg_err <= 1'b0;
            r_fix     <= 1'b0;
        end else begin
            r_out     <= w_next;
            r_cfg_err <= cfg_we & ~w_cfg_ok;
            r_fix     <= cfg_we & w_cfg_ok;
            if (cfg_we && w_cfg_ok)
                r_mod <= mod_val;
        end
    end
endmodule

// File: doc/mod_updn_ctr.md
MOD_UPDN_CTR -- requirements
Module: mod_updn_ctr

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (2..16).
REQ-002 SHALL have parameter DEFAULT_MOD, default 10, modulus after reset (2..2**WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  WIDTH  value to load.
REQ-009 SHALL have port cfg_we  input  1  modulus write strobe.
REQ-010 SHALL have port mod_val  input  WIDTH+1  new modulus.
REQ-011 SHALL have port out  output  WIDTH  current count, registered.
REQ-012 SHALL have port tc  output  1  terminal-count / carry-out, combinational, for cascading.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected modulus write, registered.

Function
REQ-014 SHALL hold an internal modulus register mod_q (WIDTH+1 bits), the active modulus M.
REQ-015 SHALL update per cycle with priority rst > load > en; with no strobe asserted, out holds.
REQ-016 SHALL, when en=1 and up_dn=1, set out <= (out == M-1) ? 0 : out+1.
REQ-017 SHALL, when en=1 and up_dn=0, set out <= (out == 0) ? M-1 : out-1.
REQ-018 SHALL drive tc = en & (up_dn ? out == M-1 : out == 0); tc SHALL be 0 when en=0.
REQ-019 SHALL, on load=1, set out <= load_val if load_val < M, else out <= 0; en is ignored that cycle.
REQ-020 SHALL accept cfg_we=1 with 2 <= mod_val <= 2**WIDTH: mod_q <= mod_val next cycle.
REQ-021 SHALL reject cfg_we=1 with mod_val outside 2..2**WIDTH: mod_q unchanged, cfg_err=1 next cycle.
REQ-022 SHALL use the old M for that cycle's count/load when cfg_we, en and/or load coincide; the new M takes effect from the following cycle.
REQ-023 SHALL, on the cycle after an accepted modulus write, force out <= 0 if out >= new M, overriding en but not load or rst.
REQ-024 SHALL handle M = 2**WIDTH as natural binary wrap (max 2**WIDTH-1, then 0) with no overflow into a WIDTH+1 path.
REQ-025 SHALL reach out from state to state in one cycle: no latency beyond the single register stage.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set out <= 0, mod_q <= DEFAULT_MOD, cfg_err <= 0, overriding load, en and cfg_we.
REQ-027 SHALL, on reset mid-count, return out to 0 on the next edge and resume counting from 0 on the first enabled cycle after rst deasserts.
REQ-028 SHALL produce tc from the reset values while rst is high (tc = en & up_dn ? 0==M-1 : 1), and SHALL NOT gate tc with rst.

Structure
REQ-029 SHALL place in shared package mod_ctr_pkg: DIR_UP/DIR_DN constants and the legal range limits (MIN_MOD = 2).
REQ-030 SHALL be a single flat module; no sub-module is needed. Two instances SHALL cascade via tc -> en of the next stage, sharing up_dn.
REQ-031 SHALL elaborate-check DEFAULT_MOD within 2..2**WIDTH and fail elaboration otherwise.

Verification
REQ-032 Reset and wrap: rst 2 cycles, then en=1, up_dn=1 for 12 cycles -> out 0..9, 0, 1; tc high exactly while out=9.
REQ-033 Down count: en=1, up_dn=0 from reset -> out 0, 9, 8 ... 0; tc high while out=0.
REQ-034 Load: load=1, load_val=7, en=1 -> out=7 next cycle, then 8; load_val=12 with M=10 -> out=0.
REQ-035 Modulus change: out=8 with M=10, cfg_we mod_val=6 -> out=9 (old M), then 0; cfg_we mod_val=1 -> cfg_err pulse, M stays 10.
REQ-036 Full range: WIDTH=4, cfg mod_val=16, count up -> out 15 -> 0 with tc at 15; cascade of two M=10 instances counts 00..99 and wraps.
REQ-037 Reset mid-operation: rst asserted at out=5 together with load=1 -> out=0, M=DEFAULT_MOD next cycle.
